// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg
// Shared definitions for the hex entry display path.
//   SEG_BLANK   : active-low segment pattern with every segment off
//   seg_encode  : nibble -> active-low {g,f,e,d,c,b,a} pattern
//   cmd_e       : push-button commands; the enum value is also the KEY bit index
package hex_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    CMD_COMMIT = 2'd0,
    CMD_BACK   = 2'd1,
    CMD_CLEAR  = 2'd2,
    CMD_BLINK  = 2'd3
  } cmd_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_entry_controller_if.sv
// hex_entry_controller_if
// Board-side bundle of the hex entry controller.
//   KEY        : raw push-buttons, active-low
//   SW         : hex value to enter
//   HEX0..HEX3 : active-low seven-segment digits, HEX0 is digit 0
//   CURSOR     : index of the digit the next commit writes
// master = board/stimulus side, slave = controller side.
interface hex_entry_controller_if;
  logic [3:0] KEY;
  logic [3:0] SW;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [1:0] CURSOR;

  modport master (
    output KEY, SW,
    input  HEX0, HEX1, HEX2, HEX3, CURSOR
  );

  modport slave (
    input  KEY, SW,
    output HEX0, HEX1, HEX2, HEX3, CURSOR
  );
endinterface

// File: rtl/key_debounce.sv
// key_debounce
// Synchronizes and debounces one active-low push-button and emits a
// one-cycle pulse when the debounced level becomes pressed.
//   CLOCK_125_p : system clock
//   RESET       : synchronous, active-high reset
//   raw         : asynchronous, bouncing key level (0 = pressed)
//   level       : debounced level (1 = released)
//   press       : registered one-cycle press pulse
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_250_000
) (
  input  logic CLOCK_125_p,
  input  logic RESET,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic          armed_r;
  logic [CW-1:0] cnt_r;

  // Synchronizer, stability counter, debounced level and press pulse.
  // The synchronizer resets to "pressed" and armed_r stays low until a
  // released sample is seen, so a key held through reset cannot fire.
  always_ff @(posedge CLOCK_125_p) begin
    if (RESET) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b1;
      press_r <= 1'b0;
      armed_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (level_r && sync2_r) begin
        armed_r <= 1'b1;
      end
      if (sync2_r == level_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_MAX) begin
        // Counter has seen the full run of differing samples: accept it.
        level_r <= sync2_r;
        cnt_r   <= {CW{1'b0}};
        press_r <= armed_r & ~sync2_r;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/hex_entry_controller.sv
// hex_entry_controller
// Four-digit hex entry onto HEX0..HEX3 with a blinking cursor.
//   CLOCK_125_p : system clock, all state on the rising edge
//   RESET       : synchronous, active-high reset
//   bus         : board bundle (KEY, SW in; HEX0..HEX3, CURSOR out)
// KEY0 commits SW into the cursor digit and advances, KEY1 steps back,
// KEY2 clears all digits, KEY3 toggles cursor blinking.
module hex_entry_controller
  import hex_disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_250_000,
  parameter int BLINK_CYCLES    = 62_500_000
) (
  input  logic                   CLOCK_125_p,
  input  logic                   RESET,
  hex_entry_controller_if.slave  bus
);

  localparam int BW = $clog2(BLINK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [3:0]      key_press_s;
  logic [3:0]      key_level_unused_s;
  logic [3:0]      sw_sync1_r;
  logic [3:0]      sw_sync2_r;

  logic [3:0][3:0] digit_r;
  logic [3:0]      valid_r;
  logic [1:0]      cursor_r;
  logic            blink_en_r;
  logic [BW-1:0]   blink_cnt_r;
  logic            phase_r;

  logic [3:0][3:0] digit_nx_s;
  logic [3:0]      valid_nx_s;
  logic [1:0]      cursor_nx_s;
  logic            blink_en_nx_s;
  logic [BW-1:0]   blink_cnt_nx_s;
  logic            phase_nx_s;
  logic            restart_s;

  logic            cmd_commit_s;
  logic            cmd_back_s;
  logic            cmd_clear_s;
  logic            cmd_blink_s;

  logic [3:0][6:0] disp_s;
  logic [3:0][6:0] hex_r;
  logic [1:0]      cursor_out_r;

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .CLOCK_125_p(CLOCK_125_p),
      .RESET      (RESET),
      .raw        (bus.KEY[gi]),
      .level      (key_level_unused_s[gi]),
      .press      (key_press_s[gi])
    );
  end

  assign cmd_commit_s = key_press_s[CMD_COMMIT];
  assign cmd_back_s   = key_press_s[CMD_BACK];
  assign cmd_clear_s  = key_press_s[CMD_CLEAR];
  assign cmd_blink_s  = key_press_s[CMD_BLINK];

  // Two-flop synchronizer for the SW bus.
  always_ff @(posedge CLOCK_125_p) begin
    if (RESET) begin
      sw_sync1_r <= 4'h0;
      sw_sync2_r <= 4'h0;
    end else begin
      sw_sync1_r <= bus.SW;
      sw_sync2_r <= sw_sync1_r;
    end
  end

  // Command decode: CLEAR wins; COMMIT+BACK writes but leaves the cursor.
  always_comb begin
    digit_nx_s  = digit_r;
    valid_nx_s  = valid_r;
    cursor_nx_s = cursor_r;
    if (cmd_clear_s) begin
      valid_nx_s  = 4'b0000;
      cursor_nx_s = 2'd0;
    end else begin
      if (cmd_commit_s) begin
        digit_nx_s[cursor_r] = sw_sync2_r;
        valid_nx_s[cursor_r] = 1'b1;
      end else begin
        digit_nx_s = digit_r;
      end
      case ({cmd_commit_s, cmd_back_s})
        2'b10:   cursor_nx_s = cursor_r + 2'd1;
        2'b01:   cursor_nx_s = cursor_r - 2'd1;
        default: cursor_nx_s = cursor_r;
      endcase
    end
  end

  // Blink enable toggle and blink timebase; a cursor move restarts it.
  always_comb begin
    blink_en_nx_s  = blink_en_r;
    blink_cnt_nx_s = blink_cnt_r;
    phase_nx_s     = phase_r;
    if (cmd_blink_s) begin
      blink_en_nx_s = ~blink_en_r;
    end else begin
      blink_en_nx_s = blink_en_r;
    end
    restart_s = cmd_clear_s | (cursor_nx_s != cursor_r);
    if (restart_s) begin
      blink_cnt_nx_s = {BW{1'b0}};
      phase_nx_s     = 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_nx_s = {BW{1'b0}};
      phase_nx_s     = ~phase_r;
    end else begin
      blink_cnt_nx_s = blink_cnt_r + BW'(1);
      phase_nx_s     = phase_r;
    end
  end

  // Entry state registers.
  always_ff @(posedge CLOCK_125_p) begin
    if (RESET) begin
      digit_r     <= {4{4'h0}};
      valid_r     <= 4'b0000;
      cursor_r    <= 2'd0;
      blink_en_r  <= 1'b1;
      blink_cnt_r <= {BW{1'b0}};
      phase_r     <= 1'b0;
    end else begin
      digit_r     <= digit_nx_s;
      valid_r     <= valid_nx_s;
      cursor_r    <= cursor_nx_s;
      blink_en_r  <= blink_en_nx_s;
      blink_cnt_r <= blink_cnt_nx_s;
      phase_r     <= phase_nx_s;
    end
  end

  // Per-digit display: blank when invalid or when the cursor digit is
  // in the off half of the blink.
  always_comb begin
    disp_s = {4{SEG_BLANK}};
    for (int i = 0; i < 4; i++) begin
      if (!valid_r[i]) begin
        disp_s[i] = SEG_BLANK;
      end else if (blink_en_r && phase_r && (cursor_r == 2'(i))) begin
        disp_s[i] = SEG_BLANK;
      end else begin
        disp_s[i] = seg_encode(digit_r[i]);
      end
    end
  end

  // Output register stage driving the display pins.
  always_ff @(posedge CLOCK_125_p) begin
    if (RESET) begin
      hex_r        <= {4{SEG_BLANK}};
      cursor_out_r <= 2'd0;
    end else begin
      hex_r        <= disp_s;
      cursor_out_r <= cursor_r;
    end
  end

  assign bus.HEX0   = hex_r[0];
  assign bus.HEX1   = hex_r[1];
  assign bus.HEX2   = hex_r[2];
  assign bus.HEX3   = hex_r[3];
  assign bus.CURSOR = cursor_out_r;

endmodule

// File: tb/tb_hex_entry_controller.sv
// tb_hex_entry_controller
// Self-checking bench: fixed vector table, randomized commands against a
// behavioural model, and hand sequences for latency, bounce and blink.
module tb_hex_entry_controller;

  localparam int D = 4;
  localparam int B = 8;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [3:0] keys;   // 1 = press that key
    logic [3:0] sw;
    logic [6:0] h0, h1, h2, h3;
    logic [1:0] cur;
  } vec_t;

  logic CLOCK_125_p = 1'b0;
  logic RESET;
  hex_entry_controller_if bus();

  hex_entry_controller #(
    .DEBOUNCE_CYCLES(D),
    .BLINK_CYCLES   (B)
  ) dut (
    .CLOCK_125_p(CLOCK_125_p),
    .RESET      (RESET),
    .bus        (bus)
  );

  always #4 CLOCK_125_p = ~CLOCK_125_p;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  logic [3:0] m_digit [4];
  logic       m_valid [4];
  int         m_cur;
  logic       m_blink;

  vec_t tbl [16];

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3, input logic [1:0] ec);
    check({name, ".HEX0"}, bus.HEX0, e0);
    check({name, ".HEX1"}, bus.HEX1, e1);
    check({name, ".HEX2"}, bus.HEX2, e2);
    check({name, ".HEX3"}, bus.HEX3, e3);
    check({name, ".CURSOR"}, {5'd0, bus.CURSOR}, {5'd0, ec});
  endtask

  function automatic logic [6:0] m_seg(input int i);
    return m_valid[i] ? SEG_TBL[m_digit[i]] : 7'h7F;
  endfunction

  task automatic check_model(input string name);
    check_all(name, m_seg(0), m_seg(1), m_seg(2), m_seg(3), 2'(m_cur));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_digit[i] = 4'h0;
      m_valid[i] = 1'b0;
    end
    m_cur   = 0;
    m_blink = 1'b1;
  endtask

  // One simultaneous set of presses, in command terms.
  task automatic model_apply(input logic [3:0] keys, input logic [3:0] sw);
    if (keys[2]) begin
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
      m_cur = 0;
    end else begin
      if (keys[0]) begin
        m_digit[m_cur] = sw;
        m_valid[m_cur] = 1'b1;
      end
      m_cur = (m_cur + (keys[0] ? 1 : 0) - (keys[1] ? 1 : 0) + 4) % 4;
    end
    if (keys[3]) m_blink = ~m_blink;
  endtask

  task automatic press(input logic [3:0] keys, input logic [3:0] sw);
    @(negedge CLOCK_125_p);
    bus.SW  = sw;
    bus.KEY = ~keys;
    repeat (D + 6) @(negedge CLOCK_125_p);
    bus.KEY = 4'hF;
    repeat (D + 6) @(negedge CLOCK_125_p);
  endtask

  initial begin
    logic [3:0] k;
    logic [3:0] s;
    int         old_cur;

    RESET   = 1'b1;
    bus.KEY = 4'hF;
    bus.SW  = 4'h0;
    repeat (3) @(negedge CLOCK_125_p);
    RESET = 1'b0;
    repeat (20) @(negedge CLOCK_125_p);
    check_all("reset_idle", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 2'd0);

    // ---- table-driven sequence (blink toggled off first) ----
    tbl[0]  = '{4'b1000, 4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 2'd0};
    tbl[1]  = '{4'b0001, 4'h3, 7'h30, 7'h7F, 7'h7F, 7'h7F, 2'd1};
    tbl[2]  = '{4'b0001, 4'hA, 7'h30, 7'h08, 7'h7F, 7'h7F, 2'd2};
    tbl[3]  = '{4'b0100, 4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 2'd0};
    tbl[4]  = '{4'b0001, 4'h1, 7'h79, 7'h7F, 7'h7F, 7'h7F, 2'd1};
    tbl[5]  = '{4'b0001, 4'h2, 7'h79, 7'h24, 7'h7F, 7'h7F, 2'd2};
    tbl[6]  = '{4'b0001, 4'h3, 7'h79, 7'h24, 7'h30, 7'h7F, 2'd3};
    tbl[7]  = '{4'b0001, 4'h4, 7'h79, 7'h24, 7'h30, 7'h19, 2'd0};
    tbl[8]  = '{4'b0001, 4'hF, 7'h0E, 7'h24, 7'h30, 7'h19, 2'd1};
    tbl[9]  = '{4'b0010, 4'h0, 7'h0E, 7'h24, 7'h30, 7'h19, 2'd0};
    tbl[10] = '{4'b0010, 4'h0, 7'h0E, 7'h24, 7'h30, 7'h19, 2'd3};
    tbl[11] = '{4'b0011, 4'h5, 7'h0E, 7'h24, 7'h30, 7'h12, 2'd3};
    tbl[12] = '{4'b0101, 4'h7, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 2'd0};
    tbl[13] = '{4'b0001, 4'h0, 7'h40, 7'h7F, 7'h7F, 7'h7F, 2'd1};
    tbl[14] = '{4'b0011, 4'h8, 7'h40, 7'h00, 7'h7F, 7'h7F, 2'd1};
    tbl[15] = '{4'b0110, 4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 2'd0};

    for (int i = 0; i < 16; i++) begin
      press(tbl[i].keys, tbl[i].sw);
      check_all($sformatf("tbl%0d", i), tbl[i].h0, tbl[i].h1, tbl[i].h2, tbl[i].h3, tbl[i].cur);
    end

    // ---- randomized commands against the model (blink stays off) ----
    model_reset();
    m_blink = 1'b0;
    for (int i = 0; i < 40; i++) begin
      k = 4'($urandom_range(1, 7));
      s = 4'($urandom_range(0, 15));
      press(k, s);
      model_apply(k, s);
      check_model($sformatf("rnd%0d_k%h_sw%h", i, k, s));
    end

    // ---- exact commit latency ----
    s = 4'($urandom_range(0, 15));
    old_cur = m_cur;
    @(negedge CLOCK_125_p);
    bus.SW  = s;
    bus.KEY = 4'b1110;
    @(posedge CLOCK_125_p);                 // edge 0
    repeat (D + 3) @(posedge CLOCK_125_p);  // edge D+3
    #1 check("lat_before", {5'd0, bus.CURSOR}, 7'(old_cur));
    @(posedge CLOCK_125_p);                 // edge D+4
    model_apply(4'b0001, s);
    #1 check("lat_after", {5'd0, bus.CURSOR}, 7'(m_cur));
    check("lat_digit", m_seg(old_cur),
          (old_cur == 0) ? bus.HEX0 : (old_cur == 1) ? bus.HEX1 :
          (old_cur == 2) ? bus.HEX2 : bus.HEX3);
    @(negedge CLOCK_125_p);
    bus.KEY = 4'hF;
    repeat (D + 6) @(negedge CLOCK_125_p);

    // ---- bouncing KEY0: exactly one commit ----
    s = 4'($urandom_range(0, 15));
    bus.SW = s;
    for (int r = 0; r < 5; r++) begin
      bus.KEY = 4'b1110;
      repeat (3) @(negedge CLOCK_125_p);
      bus.KEY = 4'b1111;
      @(negedge CLOCK_125_p);
    end
    bus.KEY = 4'b1110;
    repeat (10) @(negedge CLOCK_125_p);
    bus.KEY = 4'b1111;
    repeat (12) @(negedge CLOCK_125_p);
    model_apply(4'b0001, s);
    check_model("bounce");

    // ---- blink: reset enables it; cursor 2 with a valid digit ----
    @(negedge CLOCK_125_p);
    RESET = 1'b1;
    @(negedge CLOCK_125_p);
    RESET = 1'b0;
    model_reset();
    repeat (5) @(negedge CLOCK_125_p);
    press(4'b0001, 4'h1);
    press(4'b0001, 4'h2);
    press(4'b0001, 4'h6);
    @(negedge CLOCK_125_p);
    bus.KEY = 4'b1101;                      // BACK: cursor 3 -> 2
    @(posedge CLOCK_125_p);                 // edge 0
    repeat (D + 4) @(posedge CLOCK_125_p);  // edge D+4: phase restarted, visible
    for (int c = 0; c < 4 * B; c++) begin
      #1;
      check($sformatf("blink_hex2_c%0d", c), bus.HEX2, (((c / B) % 2) == 0) ? SEG_TBL[6] : 7'h7F);
      check($sformatf("blink_hex0_c%0d", c), bus.HEX0, SEG_TBL[1]);
      check($sformatf("blink_hex3_c%0d", c), bus.HEX3, 7'h7F);
      @(posedge CLOCK_125_p);
    end
    #1 check("blink_hex1", bus.HEX1, SEG_TBL[2]);
    check("blink_cursor", {5'd0, bus.CURSOR}, 7'd2);

    // ---- reset mid-blink ----
    @(negedge CLOCK_125_p);
    bus.KEY = 4'hF;
    RESET   = 1'b1;
    @(posedge CLOCK_125_p);
    #1 check_all("reset_mid_blink", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 2'd0);
    @(negedge CLOCK_125_p);
    RESET = 1'b0;
    repeat (4) @(negedge CLOCK_125_p);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
